// File: rtl/aes_encrypt_iter_if.sv
// rtl/aes_encrypt_iter_if.sv - start/busy/done block interface for the iterative AES-256 encrypt core
interface aes_encrypt_iter_if #(
  parameter int KW = 1920
);
  logic          start;
  logic [127:0]  plaintext;
  logic [KW-1:0] round_keys;
  logic          busy;
  logic          done;
  logic [127:0]  ciphertext;

  modport master (
    output start, plaintext, round_keys,
    input  busy, done, ciphertext
  );

  modport slave (
    input  start, plaintext, round_keys,
    output busy, done, ciphertext
  );
endinterface

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-256 encryption core, one round per clock
module aes_encrypt_iter #(
  parameter int NR = 14,
  parameter int KW = 128*(NR+1)
) (
  input logic          clk,
  input logic          rst,
  aes_encrypt_iter_if.slave io
);

  typedef enum logic {IDLE, RUN} fsm_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = 11'd2047 - {x, 3'b000};
    return SBOX[base -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r sits in row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Round keys are read live from the port every round, never latched.
  logic [127:0] rk [NR+1];
  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = io.round_keys[KW-1-128*r -: 128];
  end

  fsm_t         st, st_n;
  logic [127:0] state_q, state_n;
  logic [3:0]   rnd, rnd_n;
  logic [127:0] ct_q, ct_n;
  logic         done_q, done_n;
  logic [127:0] sb_sr, mixed;

  assign sb_sr         = shift_rows(sub_bytes(state_q));
  assign mixed         = mix_columns(sb_sr);
  assign io.busy       = (st == RUN);
  assign io.done       = done_q;
  assign io.ciphertext = ct_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      state_q <= '0;
      rnd     <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      st      <= st_n;
      state_q <= state_n;
      rnd     <= rnd_n;
      ct_q    <= ct_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    st_n    = st;
    state_n = state_q;
    rnd_n   = rnd;
    ct_n    = ct_q;
    done_n  = 1'b0;
    case (st)
      IDLE: begin
        if (io.start) begin
          state_n = io.plaintext ^ rk[0];
          rnd_n   = 4'd1;
          st_n    = RUN;
        end
      end
      RUN: begin
        // Final round drops MixColumns and lands straight in the output register.
        if (rnd == 4'(NR)) begin
          ct_n   = sb_sr ^ rk[rnd];
          done_n = 1'b1;
          rnd_n  = 4'd0;
          st_n   = IDLE;
        end else begin
          state_n = mixed ^ rk[rnd];
          rnd_n   = rnd + 4'd1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES-256 encryption core, the forward-direction counterpart of the existing decrypt datapath. It takes a 128-bit plaintext and the 1920-bit expanded key schedule produced by KeyExpansion#(8,14), and executes one AES round per clock. It returns the 128-bit ciphertext with a start/busy/done handshake. It sits beside the decrypt block so that encrypt→decrypt round trips can be checked on the board.

## Interface
- NR, 14, number of rounds; fixed at 14 for AES-256, other values unsupported.
- KW, 128*(NR+1), expanded-key width (1920).

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to encrypt; sampled only when busy=0.
- plaintext  input  128  block to encrypt; sampled on the accepting edge.
- round_keys  input  KW  expanded key; round key r = round_keys[KW-1-128*r -: 128] (rk0 in the top 128 bits, FIPS-197 word order w0 first).
- busy  output  1  high while a block is in flight.
- done  output  1  one-cycle pulse when ciphertext is valid and newly updated.
- ciphertext  output  128  result register; holds its value until the next completion.

## Operation
- Byte order: state byte 0 = bits [127:120]; bytes fill the state column-major (s[r][c] = byte 4c+r), as in FIPS-197.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- Round counter rnd is 4 bits, range 1..NR.
- IDLE with start=1: state ← plaintext ^ rk0, rnd ← 1, go to RUN.
- IDLE with start=0: hold.
- RUN with rnd < NR: state ← MixColumns(ShiftRows(SubBytes(state))) ^ rk[rnd], rnd ← rnd+1.
- RUN with rnd = NR: ciphertext ← ShiftRows(SubBytes(state)) ^ rk[NR] (no MixColumns), done ← 1, go to IDLE.
- SubBytes: 16 parallel forward S-box lookups, combinational.
- MixColumns arithmetic: GF(2^8), xtime with reduction polynomial 0x11B.
- Key schedule hold: round_keys is read every RUN cycle and is not latched. The driver must hold it stable from the accepting edge through the done cycle; changing it mid-block gives an undefined ciphertext.
- plaintext is only sampled on the accepting edge and may change afterwards.
- start while busy=1 is ignored: no queueing, no effect on the block in flight.

## Timing
- Reset values: busy=0, done=0, ciphertext=0, internal state=0, rnd=0, FSM=IDLE.
- Latency: start accepted at edge T0; rounds 1..14 execute at edges T1..T14.
- At T14 ciphertext updates, done=1 and busy=0. Both are visible in the cycle after T14, which is 14 cycles after the accepting edge.
- busy: rises in the cycle after T0 and stays high for exactly 14 cycles (T0..T13 edges).
- done: high for exactly one cycle. It is cleared on the next edge unless that edge completes another block, which is impossible within 14 cycles.
- Throughput: one block per 15 cycles at best. start held high continuously is accepted again in the done cycle, so a new block begins at T15 if start=1 then.
- Reset mid-operation (rst=1 during RUN): the block is aborted and no done is issued. ciphertext is cleared to 0 and the core is in IDLE on the next cycle.
- Simultaneous rst and start: rst wins and start is ignored.

## Test plan
- FIPS-197 C.3: key 000102…1e1f (via KeyExpansion#(8,14)), plaintext 00112233445566778899aabbccddeeff, start pulse → done exactly 14 cycles later, ciphertext = 8ea2b7ca516745bfeafc49904b496089, busy high for 14 cycles.
- All-zero key and plaintext → ciphertext = dc95c078a2408989ad48a21492842087. After that, ciphertext holds with done=0 for 20 idle cycles.
- Start pulses at cycles +3 and +10 while busy → ignored; exactly one done; result identical to the C.3 vector.
- start held high for 40 cycles with the C.3 inputs → done pulses at +14 and +29, both with 8ea2b7ca…6089; busy low only in the done cycles.
- rst asserted at round 7 of a C.3 encryption → no done; next cycle busy=0, ciphertext=0. A fresh start afterwards gives the correct result 14 cycles later.
- Round trip: ciphertext from the C.3 run fed to the decrypt block with the same expanded key → recovered 00112233445566778899aabbccddeeff.
